// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC/data widths, fetch FSM state type, mod-512 PC adder.
// Optional build macro: IFETCH_SINGLE_STEP_EN adds the STEP_WAIT state.
package cpu_pkg;

    localparam int unsigned PC_W   = 9;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        F0,
        F1,
        F2,
        F3,
        ISSUE,
        EXEC,
        HALT
`ifdef IFETCH_SINGLE_STEP_EN
        , STEP_WAIT
`endif
    } fetch_state_t;

    // PC_W-bit add; the carry out is dropped so addresses wrap past 0x1FF to 0x000.
    function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] a, input logic [1:0] n);
        return a + PC_W'(n);
    endfunction

endpackage

// File: rtl/ifetch_pc.sv
// Program counter register and next-pc mux (hold / +size / jump / reset).
module ifetch_pc
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            i_upd,
    input  logic            i_jmp_en,
    input  logic [PC_W-1:0] i_jmp_addr,
    input  logic [1:0]      i_size,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_p1,
    output logic [PC_W-1:0] o_pc_p2
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [1:0]      w_step;

    // Next-pc selection; a zero size advances by one so the core never spins in place.
    always_comb begin
        w_step    = (i_size == 2'd0) ? 2'd1 : i_size;
        w_pc_next = r_pc;
        if (i_upd) begin
            w_pc_next = i_jmp_en ? i_jmp_addr : pc_add(r_pc, w_step);
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc    = r_pc;
    assign o_pc_p1 = pc_add(r_pc, 2'd1);
    assign o_pc_p2 = pc_add(r_pc, 2'd2);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads opcode + two operand bytes from a synchronous ROM,
// issues them to the decoder, waits out the execute window and updates the PC.
// Optional build macro: IFETCH_SINGLE_STEP_EN (adds step_req port and STEP_WAIT state).
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              sys_rst,
    output logic [PC_W-1:0]   rom_addr,
    output logic              rom_rd_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr_byte,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic              cmd_start,
    input  logic [1:0]        instr_size,
    input  logic              jmp_en,
    input  logic [PC_W-1:0]   jmp_addr,
    input  logic              pc_hlt,
    input  logic              dec_busy,
`ifdef IFETCH_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    localparam logic [3:0] LP_LAST = 4'(EXEC_CYCLES - 1);

    fetch_state_t      r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic              r_cmd_start;
    logic              r_halted;

    logic [PC_W-1:0]   w_pc;
    logic [PC_W-1:0]   w_pc_p1;
    logic [PC_W-1:0]   w_pc_p2;
    logic              w_last;
    logic              w_pc_upd;
    logic [PC_W-1:0]   w_rom_addr;
    logic              w_rom_rd_en;

    // Final productive EXEC cycle: the only point where decoder results are consumed.
    assign w_last   = (r_state == EXEC) && (r_cnt == LAST_SEL()) && !dec_busy;
    assign w_pc_upd = w_last && !pc_hlt;

    function automatic logic [3:0] LAST_SEL();
        return LP_LAST;
    endfunction

    ifetch_pc u_pc (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .i_upd      (w_pc_upd),
        .i_jmp_en   (jmp_en),
        .i_jmp_addr (jmp_addr),
        .i_size     (instr_size),
        .o_pc       (w_pc),
        .o_pc_p1    (w_pc_p1),
        .o_pc_p2    (w_pc_p2)
    );

    // ROM strobe/address decoded from the fetch state; gated by reset so the very
    // first cycle after reset release already presents address 0 with the strobe up.
    always_comb begin
        w_rom_addr  = '0;
        w_rom_rd_en = 1'b0;
        if (sys_rst) begin
            case (r_state)
                F0:      begin w_rom_addr = w_pc;    w_rom_rd_en = 1'b1; end
                F1:      begin w_rom_addr = w_pc_p1; w_rom_rd_en = 1'b1; end
                F2:      begin w_rom_addr = w_pc_p2; w_rom_rd_en = 1'b1; end
                default: ;
            endcase
        end
    end

    // Fetch/issue/execute sequencer with byte latches, execute counter and registered flags.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            r_state     <= F0;
            r_cnt       <= '0;
            r_instr     <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_cmd_start <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                F0: r_state <= F1;
                F1: begin
                    r_instr <= rom_data;
                    r_state <= F2;
                end
                F2: begin
                    r_op1   <= rom_data;
                    r_state <= F3;
                end
                F3: begin
                    r_op2       <= rom_data;
                    r_cmd_start <= 1'b1;
                    r_state     <= ISSUE;
                end
                ISSUE: begin
                    r_cmd_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= EXEC;
                end
                EXEC: begin
                    if (!dec_busy) begin
                        if (r_cnt == LP_LAST) begin
                            r_cnt <= '0;
                            if (pc_hlt) begin
                                r_halted <= 1'b1;
                                r_state  <= HALT;
                            end else begin
`ifdef IFETCH_SINGLE_STEP_EN
                                r_state <= STEP_WAIT;
`else
                                r_state <= F0;
`endif
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
`ifdef IFETCH_SINGLE_STEP_EN
                STEP_WAIT: begin
                    if (step_req) begin
                        r_state <= F0;
                    end
                end
`endif
                HALT: r_halted <= 1'b1;
                default: r_state <= F0;
            endcase
        end
    end

    assign rom_addr   = w_rom_addr;
    assign rom_rd_en  = w_rom_rd_en;
    assign instr_byte = r_instr;
    assign operand1   = r_op1;
    assign operand2   = r_op2;
    assign cmd_start  = r_cmd_start;
    assign pc         = w_pc;
    assign halted     = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch (default build) with a cycle-level model.
module tb_instr_fetch;

    localparam int unsigned EXEC = 4;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [8:0] rom_addr;
    logic       rom_rd_en;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] instr_byte, operand1, operand2;
    logic       cmd_start;
    logic [1:0] instr_size = 2'd1;
    logic       jmp_en = 1'b0;
    logic [8:0] jmp_addr = 9'h000;
    logic       pc_hlt = 1'b0;
    logic       dec_busy = 1'b0;
    logic [8:0] pc;
    logic       halted;

    logic [7:0] rom [0:511];

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch #(.EXEC_CYCLES(EXEC)) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .rom_addr   (rom_addr),
        .rom_rd_en  (rom_rd_en),
        .rom_data   (rom_data),
        .instr_byte (instr_byte),
        .operand1   (operand1),
        .operand2   (operand2),
        .cmd_start  (cmd_start),
        .instr_size (instr_size),
        .jmp_en     (jmp_en),
        .jmp_addr   (jmp_addr),
        .pc_hlt     (pc_hlt),
        .dec_busy   (dec_busy),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom[rom_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] add9(input logic [8:0] a, input int unsigned n);
        return a + 9'(n);
    endfunction

    // Model: m_k is the cycle offset inside the current instruction (0..3 fetch,
    // 4 issue, 5 execute), m_left the productive execute cycles still owed.
    logic       m_valid = 1'b0;
    int         m_k = 0;
    int         m_left = 0;
    logic [8:0] m_pc = '0;
    logic       m_halted = 1'b0;
    logic [7:0] m_ib = '0, m_op1 = '0, m_op2 = '0;

    always @(posedge clk) begin
        if (!sys_rst) begin
            m_valid <= 1'b1; m_k <= 0; m_left <= 0; m_pc <= '0; m_halted <= 1'b0;
            m_ib <= '0; m_op1 <= '0; m_op2 <= '0;
        end else if (!m_halted) begin
            if (m_k < 4) begin
                if (m_k == 1) m_ib  <= rom[m_pc];
                if (m_k == 2) m_op1 <= rom[add9(m_pc, 1)];
                if (m_k == 3) m_op2 <= rom[add9(m_pc, 2)];
                m_k <= m_k + 1;
            end else if (m_k == 4) begin
                m_k <= 5;
                m_left <= EXEC;
            end else if (!dec_busy) begin
                if (m_left == 1) begin
                    m_k <= 0;
                    if (pc_hlt) m_halted <= 1'b1;
                    else if (jmp_en) m_pc <= jmp_addr;
                    else m_pc <= add9(m_pc, (instr_size == 2'd0) ? 1 : int'(instr_size));
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    logic exp_rd;
    always @(negedge clk) begin
        if (m_valid) begin
            exp_rd = sys_rst && !m_halted && (m_k <= 2);
            chk("rom_rd_en", rom_rd_en, exp_rd);
            if (exp_rd) chk("rom_addr", rom_addr, add9(m_pc, m_k));
            chk("cmd_start", cmd_start, !m_halted && (m_k == 4));
            chk("halted", halted, m_halted);
            chk("pc", pc, m_pc);
            chk("instr_byte", instr_byte, m_ib);
            chk("operand1", operand1, m_op1);
            chk("operand2", operand2, m_op2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default();
        instr_size = 2'd1; jmp_en = 1'b0; jmp_addr = 9'h000; pc_hlt = 1'b0; dec_busy = 1'b0;
    endtask

    task automatic set_junk();
        instr_size = 2'd3; jmp_en = 1'b1; jmp_addr = 9'h155; pc_hlt = 1'b1;
    endtask

    // Entered on an F0 cycle; returns on the following F0 (or first HALT) cycle.
    task automatic run_instr(input logic j, input logic [8:0] ja, input logic [1:0] sz,
                             input logic h, input int unsigned stalls);
        repeat (5) cyc();
        for (int unsigned s = 0; s < stalls; s++) begin
            set_junk(); dec_busy = 1'b1; cyc();
        end
        dec_busy = 1'b0;
        for (int unsigned i = 1; i < EXEC; i++) begin
            set_junk(); cyc();
        end
        jmp_en = j; jmp_addr = ja; instr_size = sz; pc_hlt = h;
        cyc();
        set_default();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 8'(i * 7 + 3);
        rom[0] = 8'h01; rom[1] = 8'hAA; rom[2] = 8'hBB;
        rom[9'h1FE] = 8'hC3; rom[9'h1FF] = 8'hD4;

        repeat (2) cyc();
        chk("rst_rd_en", rom_rd_en, 1'b0);
        chk("rst_pc", pc, 9'h000);
        chk("rst_cmd", cmd_start, 1'b0);
        chk("rst_halted", halted, 1'b0);

        sys_rst = 1'b1; #1;
        chk("c0_addr", rom_addr, 9'h000);
        chk("c0_rd_en", rom_rd_en, 1'b1);
        chk("c0_ib", instr_byte, 8'h00);
        cyc(); chk("c1_addr", rom_addr, 9'h001);
        cyc(); chk("c2_addr", rom_addr, 9'h002);
        cyc(); chk("c3_rd_en", rom_rd_en, 1'b0);
        cyc(); chk("c4_cmd", cmd_start, 1'b1);
        chk("c4_ib", instr_byte, 8'h01);
        chk("c4_op1", operand1, 8'hAA);
        chk("c4_op2", operand2, 8'hBB);
        repeat (5) cyc();
        chk("c9_addr", rom_addr, 9'h001);
        chk("c9_pc", pc, 9'h001);

        run_instr(1'b1, 9'h062, 2'd1, 1'b0, 0);
        chk("jmp_addr", rom_addr, 9'h062);
        chk("jmp_pc", pc, 9'h062);

        run_instr(1'b1, 9'h010, 2'd1, 1'b0, 0);
        chk("jmp10_pc", pc, 9'h010);
        run_instr(1'b0, 9'h000, 2'd2, 1'b0, 0);
        chk("size2_pc", pc, 9'h012);

        run_instr(1'b1, 9'h1FE, 2'd1, 1'b0, 0);
        chk("wrap_start", rom_addr, 9'h1FE);
        run_instr(1'b0, 9'h000, 2'd3, 1'b0, 0);
        chk("wrap_pc", pc, 9'h001);
        chk("wrap_ib", instr_byte, 8'hC3);
        chk("wrap_op1", operand1, 8'hD4);
        chk("wrap_op2", operand2, 8'h01);

        run_instr(1'b0, 9'h000, 2'd0, 1'b0, 3);
        chk("stall_pc", pc, 9'h002);
        chk("stall_rd_en", rom_rd_en, 1'b1);
        chk("stall_addr", rom_addr, 9'h002);

        cyc(); cyc();
        sys_rst = 1'b0;
        cyc();
        sys_rst = 1'b1; #1;
        chk("abort_pc", pc, 9'h000);
        chk("abort_addr", rom_addr, 9'h000);
        chk("abort_rd_en", rom_rd_en, 1'b1);
        cyc(); chk("abort_cmd1", cmd_start, 1'b0);
        cyc(); cyc(); chk("abort_cmd3", cmd_start, 1'b0);
        cyc(); chk("restart_cmd", cmd_start, 1'b1);
        chk("restart_ib", instr_byte, 8'h01);
        repeat (5) cyc();
        chk("restart_pc", pc, 9'h001);

        run_instr(1'b1, 9'h0AA, 2'd1, 1'b1, 0);
        chk("halt_flag", halted, 1'b1);
        chk("halt_pc", pc, 9'h001);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("halt_rd_en", rom_rd_en, 1'b0);
            chk("halt_cmd", cmd_start, 1'b0);
        end

        sys_rst = 1'b0;
        cyc();
        sys_rst = 1'b1; #1;
        chk("unhalt_flag", halted, 1'b0);
        chk("unhalt_rd_en", rom_rd_en, 1'b1);
        chk("unhalt_addr", rom_addr, 9'h000);
        repeat (12) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
